// File: rtl/mcycle_maindec.sv
// mcycle_maindec: main control FSM of the 8-bit multicycle MIPS core.
// Sequences a four-byte instruction fetch, decode, and the per-opcode
// execute / memory / writeback states, driving the datapath enables and
// mux selects plus the 2-bit aluop consumed by the ALU control decoder.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   op[5:0]             opcode field IR[31:26]
//   zero                ALU zero flag (same cycle), used only for pcen in BEQEX
//   memread, memwrite   memory strobes
//   alusrca, alusrcb    ALU operand selects
//   aluop               00=add, 01=sub, 10=use funct
//   pcsource            00=ALU result, 01=ALUOut, 10=jump target
//   pcen                PC load enable = pcwrite | (pcwritecond & zero)
//   iord                memory address select, 0=PC, 1=ALUOut
//   irwrite[3:0]        one-hot IR byte-lane write enable
//   regdst, memtoreg    register-file write address / data selects
//   regwrite            register-file write enable
module mcycle_maindec #(
  parameter logic [5:0] OP_LB    = 6'b100000,
  parameter logic [5:0] OP_SB    = 6'b101000,
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_J     = 6'b000010,
  parameter logic [5:0] OP_ADDI  = 6'b001000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       pcen,
  output logic       iord,
  output logic [3:0] irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite
);

  localparam int unsigned STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_ADDIWR  = 4'd9,
    S_RTYPEEX = 4'd10,
    S_RTYPEWR = 4'd11,
    S_BEQEX   = 4'd12,
    S_JEX     = 4'd13
  } state_t;

  // Full control word for one state; pcwrite/pcwritecond stay internal.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;

  state_t state;
  state_t state_d;
  ctrl_t  ctrl_q;
  ctrl_t  ctrl;
  logic   state_legal;

  // Next-state rule; unknown states and unknown opcodes fall back to FETCH1.
  function automatic state_t next_of(input state_t s, input logic [5:0] o);
    state_t n;
    n = S_FETCH1;
    case (s)
      S_FETCH1:  n = S_FETCH2;
      S_FETCH2:  n = S_FETCH3;
      S_FETCH3:  n = S_FETCH4;
      S_FETCH4:  n = S_DECODE;
      S_DECODE: begin
        if (o == OP_LB || o == OP_SB || o == OP_ADDI) n = S_MEMADR;
        else if (o == OP_RTYPE)                       n = S_RTYPEEX;
        else if (o == OP_BEQ)                         n = S_BEQEX;
        else if (o == OP_J)                           n = S_JEX;
        else                                          n = S_FETCH1;
      end
      S_MEMADR: begin
        if (o == OP_LB)        n = S_LBRD;
        else if (o == OP_SB)   n = S_SBWR;
        else if (o == OP_ADDI) n = S_ADDIWR;
        else                   n = S_FETCH1;
      end
      S_LBRD:    n = S_LBWR;
      S_RTYPEEX: n = S_RTYPEWR;
      default:   n = S_FETCH1;
    endcase
    return n;
  endfunction

  // Moore control word per state; anything not named stays 0.
  function automatic ctrl_t ctrl_of(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        c.memread = 1'b1;
        c.alusrcb = 2'b01;
        c.pcwrite = 1'b1;
        case (s)
          S_FETCH1: c.irwrite = 4'b0001;
          S_FETCH2: c.irwrite = 4'b0010;
          S_FETCH3: c.irwrite = 4'b0100;
          default:  c.irwrite = 4'b1000;
        endcase
      end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_LBRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_LBWR: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_SBWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_ADDIWR:  c.regwrite = 1'b1;
      S_RTYPEEX: begin
        c.alusrca = 1'b1;
        c.aluop   = 2'b10;
      end
      S_RTYPEWR: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_BEQEX: begin
        c.alusrca     = 1'b1;
        c.aluop       = 2'b01;
        c.pcwritecond = 1'b1;
        c.pcsource    = 2'b01;
      end
      S_JEX: begin
        c.pcwrite  = 1'b1;
        c.pcsource = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign state_d = next_of(state, op);

  // State and control word advance together, so the control flops always
  // hold the decode of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_FETCH1;
      ctrl_q <= ctrl_of(S_FETCH1);
    end else begin
      state  <= state_d;
      ctrl_q <= ctrl_of(state_d);
    end
  end

  // An upset into an unused encoding must not leak a stale control word.
  assign state_legal = (state <= S_JEX);
  assign ctrl        = state_legal ? ctrl_q : '0;

  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign alusrca  = ctrl.alusrca;
  assign alusrcb  = ctrl.alusrcb;
  assign aluop    = ctrl.aluop;
  assign pcsource = ctrl.pcsource;
  assign iord     = ctrl.iord;
  assign irwrite  = ctrl.irwrite;
  assign regdst   = ctrl.regdst;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;

  // zero is only consulted while pcwritecond is set, so an undriven flag
  // outside BEQEX cannot reach pcen.
  assign pcen = ctrl.pcwrite | (ctrl.pcwritecond ? zero : 1'b0);

endmodule

// File: tb/tb_mcycle_maindec.sv
// tb_mcycle_maindec: self-checking bench for mcycle_maindec. A reference
// model expands each opcode into its expected per-cycle control pattern
// (fetch bytes, decode, then the instruction's own steps) and the bench
// compares the DUT cycle by cycle under directed and random opcodes.
module tb_mcycle_maindec;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam int PC_NEVER  = 0;
  localparam int PC_ALWAYS = 1;
  localparam int PC_IFZERO = 2;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       iord;
    logic [3:0] irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
  } obs_t;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memread, memwrite, alusrca, pcen, iord, regdst, memtoreg, regwrite;
  logic [1:0] alusrcb, aluop, pcsource;
  logic [3:0] irwrite;

  int n_checks;
  int n_fail;

  obs_t exp_q[$];
  int   pcm_q[$];

  mcycle_maindec dut (
    .clk      (clk),
    .reset    (reset),
    .op       (op),
    .zero     (zero),
    .memread  (memread),
    .memwrite (memwrite),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluop    (aluop),
    .pcsource (pcsource),
    .pcen     (pcen),
    .iord     (iord),
    .irwrite  (irwrite),
    .regdst   (regdst),
    .memtoreg (memtoreg),
    .regwrite (regwrite)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.memread  = memread;
    o.memwrite = memwrite;
    o.alusrca  = alusrca;
    o.alusrcb  = alusrcb;
    o.aluop    = aluop;
    o.pcsource = pcsource;
    o.iord     = iord;
    o.irwrite  = irwrite;
    o.regdst   = regdst;
    o.memtoreg = memtoreg;
    o.regwrite = regwrite;
    return o;
  endfunction

  function automatic obs_t fetch_word(input int b);
    obs_t e;
    e = '0;
    e.memread = 1'b1;
    e.alusrcb = 2'b01;
    e.irwrite = 4'(1 << b);
    return e;
  endfunction

  // Expand one instruction into its cycle-by-cycle expectation.
  task automatic build(input logic [5:0] o);
    obs_t e;
    exp_q.delete();
    pcm_q.delete();
    for (int b = 0; b < 4; b++) begin
      exp_q.push_back(fetch_word(b));
      pcm_q.push_back(PC_ALWAYS);
    end
    e = '0; e.alusrcb = 2'b11;
    exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
    if (o == OP_LB || o == OP_SB || o == OP_ADDI) begin
      e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
      exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
      if (o == OP_LB) begin
        e = '0; e.memread = 1'b1; e.iord = 1'b1;
        exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
        e = '0; e.regwrite = 1'b1; e.memtoreg = 1'b1;
        exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
      end else if (o == OP_SB) begin
        e = '0; e.memwrite = 1'b1; e.iord = 1'b1;
        exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
      end else begin
        e = '0; e.regwrite = 1'b1;
        exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
      end
    end else if (o == OP_RTYPE) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 2'b10;
      exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
      e = '0; e.regwrite = 1'b1; e.regdst = 1'b1;
      exp_q.push_back(e); pcm_q.push_back(PC_NEVER);
    end else if (o == OP_BEQ) begin
      e = '0; e.alusrca = 1'b1; e.aluop = 2'b01; e.pcsource = 2'b01;
      exp_q.push_back(e); pcm_q.push_back(PC_IFZERO);
    end else if (o == OP_J) begin
      e = '0; e.pcsource = 2'b10;
      exp_q.push_back(e); pcm_q.push_back(PC_ALWAYS);
    end
  endtask

  function automatic int cycles_of(input logic [5:0] o);
    if (o == OP_LB) return 8;
    if (o == OP_SB || o == OP_ADDI || o == OP_RTYPE) return 7;
    if (o == OP_BEQ || o == OP_J) return 6;
    return 5;
  endfunction

  // Runs one instruction starting at a negedge in FETCH1. zmode: 0 random,
  // 1 force zero=0, 2 force zero=1. abort_at >= 0 raises reset during that
  // cycle and expects FETCH1 on the following one.
  task automatic run_instr(input logic [5:0] o, input int zmode, input int abort_at);
    obs_t e;
    int   pm;
    int   idx;
    int   wcnt;
    int   rwcnt;
    logic z;
    logic exp_pcen;
    build(o);
    op    = o;
    idx   = 0;
    wcnt  = 0;
    rwcnt = 0;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      pm = pcm_q.pop_front();
      z  = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 2);
      zero = z;
      #1;
      exp_pcen = (pm == PC_ALWAYS) ? 1'b1 : (pm == PC_IFZERO) ? z : 1'b0;
      check($sformatf("op%02h c%0d ctrl", o, idx), 32'(sample()), 32'(e));
      check($sformatf("op%02h c%0d pcen", o, idx), 32'(pcen), 32'(exp_pcen));
      wcnt  += int'(memwrite);
      rwcnt += int'(regwrite);
      if (idx == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        zero = 1'($urandom_range(0, 1));
        #1;
        check($sformatf("op%02h abort ctrl", o), 32'(sample()), 32'(fetch_word(0)));
        check($sformatf("op%02h abort pcen", o), 32'(pcen), 32'h1);
        check($sformatf("op%02h abort regwrite", o), 32'(rwcnt + int'(regwrite)), 32'h0);
        reset = 1'b0;
        exp_q.delete();
        pcm_q.delete();
        return;
      end
      @(negedge clk);
      idx++;
    end
    check($sformatf("op%02h cycles", o), 32'(idx), 32'(cycles_of(o)));
    check($sformatf("op%02h memwrite_cnt", o), 32'(wcnt), 32'((o == OP_SB) ? 1 : 0));
  endtask

  initial begin
    logic [5:0] ops [8];
    logic [5:0] ro;
    n_checks = 0;
    n_fail   = 0;
    ops[0] = OP_LB;  ops[1] = OP_SB;   ops[2] = OP_RTYPE; ops[3] = OP_BEQ;
    ops[4] = OP_J;   ops[5] = OP_ADDI; ops[6] = 6'h3F;    ops[7] = 6'h11;
    reset = 1'b1;
    op    = 6'h00;
    zero  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset ctrl", 32'(sample()), 32'(fetch_word(0)));
    check("reset pcen", 32'(pcen), 32'h1);
    reset = 1'b0;

    run_instr(6'h00,  0, -1);
    run_instr(OP_LB,  0, -1);
    run_instr(OP_SB,  0, -1);
    run_instr(OP_BEQ, 2, -1);
    run_instr(OP_BEQ, 1, -1);
    run_instr(OP_RTYPE, 0, -1);
    run_instr(6'h3F,  0, -1);
    run_instr(OP_J,   0, -1);
    run_instr(OP_ADDI, 0, -1);
    run_instr(OP_LB,  0, 6);
    run_instr(OP_SB,  0, -1);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) ro = 6'($urandom_range(0, 63));
      else                           ro = ops[$urandom_range(0, 7)];
      run_instr(ro, 0, ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
